// File: rtl/shift_arbiter.sv
// Round-robin arbiter that time-shares one 8-bit barrel shifter between two requesters.
// Define SHIFT_ARB_ROT_EN to compile in rotate support (second shifter pass plus OR-accumulate).

module barrel_shifter (
  input  logic [7:0] in,
  input  logic [2:0] shamt,
  input  logic       dir,
  output logic [7:0] out
);

  assign out = dir ? (in >> shamt) : (in << shamt);

endmodule

module shift_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [2:0] req_shamt0,
  input  logic [2:0] req_shamt1,
  input  logic       req_dir0,
  input  logic       req_dir1,
  input  logic       req_rot0,
  input  logic       req_rot1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t     state_q;
  logic       last_q;
  logic       id_q;
  logic       dir_q;
  logic [2:0] shamt_q;
  logic [7:0] op_q;
  logic [7:0] acc_q;

  logic       gntId;
  logic [2:0] shiftAmt;
  logic       shiftDir;
  logic [7:0] shiftOut;

`ifdef SHIFT_ARB_ROT_EN
  logic rot_q;
  logic reqRot;
  assign reqRot = gntId ? req_rot1 : req_rot0;
`else
  logic unused_rot;
  assign unused_rot = req_rot0 ^ req_rot1;
`endif

  // On a tie the requester that was not served last wins.
  always_comb begin
    gntId = 1'b0;
    case (req_valid)
      2'b10:   gntId = 1'b1;
      2'b11:   gntId = ~last_q;
      default: gntId = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE) && (|req_valid)) begin
      req_ready[gntId] = 1'b1;
    end
  end

  // The second rotate pass shifts the opposite way by the complementary amount.
  always_comb begin
    shiftAmt = shamt_q;
    shiftDir = dir_q;
`ifdef SHIFT_ARB_ROT_EN
    if (state_q == PASS2) begin
      shiftAmt = 3'd0 - shamt_q;
      shiftDir = ~dir_q;
    end
`endif
  end

  barrel_shifter u_shifter (
    .in    (op_q),
    .shamt (shiftAmt),
    .dir   (shiftDir),
    .out   (shiftOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      dir_q   <= 1'b0;
      shamt_q <= 3'd0;
      op_q    <= 8'h00;
      acc_q   <= 8'h00;
`ifdef SHIFT_ARB_ROT_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            op_q    <= gntId ? req_data1 : req_data0;
            shamt_q <= gntId ? req_shamt1 : req_shamt0;
            dir_q   <= gntId ? req_dir1 : req_dir0;
            id_q    <= gntId;
            last_q  <= gntId;
`ifdef SHIFT_ARB_ROT_EN
            rot_q   <= reqRot;
`endif
            state_q <= PASS1;
          end
        end
        PASS1: begin
          acc_q <= shiftOut;
`ifdef SHIFT_ARB_ROT_EN
          state_q <= (rot_q && (shamt_q != 3'd0)) ? PASS2 : DONE;
`else
          state_q <= DONE;
`endif
        end
`ifdef SHIFT_ARB_ROT_EN
        PASS2: begin
          acc_q   <= acc_q | shiftOut;
          state_q <= DONE;
        end
`endif
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = acc_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed table, corner-case sequences and randomized traffic.
// Expectations follow SHIFT_ARB_ROT_EN the same way the design does.

module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_data0, req_data1;
  logic [2:0] req_shamt0, req_shamt1;
  logic       req_dir0, req_dir1;
  logic       req_rot0, req_rot1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       busy;

  int nChecks = 0;
  int nPassed = 0;

`ifdef SHIFT_ARB_ROT_EN
  localparam bit RotEn = 1'b1;
`else
  localparam bit RotEn = 1'b0;
`endif

  shift_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_shamt0 (req_shamt0),
    .req_shamt1 (req_shamt1),
    .req_dir0   (req_dir0),
    .req_dir1   (req_dir1),
    .req_rot0   (req_rot0),
    .req_rot1   (req_rot1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [2:0] shamt;
    logic       dir;
    logic       rot;
    logic [7:0] expData;
    int         expLat;
  } vec_t;

  // Reference: shifts as divide/multiply by powers of two, rotate as the sum of the two disjoint parts.
  function automatic logic [7:0] refModel(logic [7:0] d, int s, logic dr, logic rt);
    int v;
    int r;
    v = int'(d);
    if (dr) r = v / (1 << s);
    else    r = (v * (1 << s)) % 256;
    if (RotEn && rt && s != 0) begin
      if (dr) r = r + (v * (1 << (8 - s))) % 256;
      else    r = r + v / (1 << (8 - s));
    end
    return r[7:0];
  endfunction

  function automatic int refLatency(int s, logic rt);
    return (RotEn && rt && s != 0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic setRequester(input int id, input logic [7:0] d, input logic [2:0] s, input logic dr, input logic rt);
    if (id == 0) begin
      req_data0 = d; req_shamt0 = s; req_dir0 = dr; req_rot0 = rt;
    end else begin
      req_data1 = d; req_shamt1 = s; req_dir1 = dr; req_rot1 = rt;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle timeout", {31'd0, busy}, 32'd0);
  endtask

  // One request from a single requester; latency counts edges after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    int lat;
    @(negedge clk);
    rsp_ready = 1'b1;
    setRequester(v.id, v.data, v.shamt, v.dir, v.rot);
    req_valid = (v.id == 0) ? 2'b01 : 2'b10;
    #1;
    checkOutput("req_ready grant", {30'd0, req_ready}, (v.id == 0) ? 32'd1 : 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, v.expLat);
    checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, v.expData});
    checkOutput("rsp_id", {31'd0, rsp_id}, v.id);
    @(posedge clk); #1;
    checkOutput("rsp_valid cleared", {31'd0, rsp_valid}, 32'd0);
    checkOutput("busy cleared", {31'd0, busy}, 32'd0);
  endtask

  vec_t table_v[6];
  int   gId[16];
  int   gCyc[16];
  int   rId[16];
  int   rData[16];
  int   ng, nr;

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    setRequester(0, 8'h00, 3'd0, 1'b0, 1'b0);
    setRequester(1, 8'h00, 3'd0, 1'b0, 1'b0);

    table_v[0] = '{0, 8'h5D, 3'd2, 1'b1, 1'b0, 8'h17, 1};
    table_v[1] = '{1, 8'h5D, 3'd2, 1'b0, 1'b0, 8'h74, 1};
    table_v[2] = '{0, 8'h5D, 3'd2, 1'b1, 1'b1, RotEn ? 8'h57 : 8'h17, RotEn ? 2 : 1};
    table_v[3] = '{0, 8'h5D, 3'd0, 1'b1, 1'b1, 8'h5D, 1};
    table_v[4] = '{1, 8'h81, 3'd7, 1'b0, 1'b0, 8'h80, 1};
    table_v[5] = '{1, 8'h81, 3'd1, 1'b0, 1'b1, RotEn ? 8'h03 : 8'h02, RotEn ? 2 : 1};

    #1;
    checkOutput("reset req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_data", {24'd0, rsp_data}, 32'd0);
    checkOutput("reset rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);

    // Tie arbitration straight out of reset: expect 0,1,0,1 every third cycle.
    for (int i = 0; i < 16; i++) begin
      gId[i] = -1; gCyc[i] = -1; rId[i] = -1; rData[i] = -1;
    end
    ng = 0; nr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    setRequester(0, 8'h0F, 3'd1, 1'b0, 1'b0);
    setRequester(1, 8'hF0, 3'd1, 1'b1, 1'b0);
    req_valid = 2'b11;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (req_ready == 2'b01 && ng < 16) begin gId[ng] = 0; gCyc[ng] = c; ng++; end
      if (req_ready == 2'b10 && ng < 16) begin gId[ng] = 1; gCyc[ng] = c; ng++; end
      if (rsp_valid && nr < 16) begin rId[nr] = int'(rsp_id); rData[nr] = int'(rsp_data); nr++; end
      @(negedge clk);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      checkOutput("tie grant order", gId[i], i % 2);
      checkOutput("tie rsp_id", rId[i], i % 2);
      checkOutput("tie rsp_data", rData[i], (i % 2 == 0) ? 32'h1E : 32'h78);
      if (i > 0) checkOutput("tie grant spacing", gCyc[i] - gCyc[i-1], 3);
    end
    waitIdle();

    foreach (table_v[i]) applyStimulus(table_v[i]);

    // Backpressure: response must hold while consumer stalls, with both requesters pending.
    @(negedge clk);
    rsp_ready = 1'b0;
    setRequester(1, 8'hC3, 3'd3, 1'b1, 1'b0);
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int n = 0; n < 10 && !rsp_valid; n++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp rsp_data", {24'd0, rsp_data}, {24'd0, refModel(8'hC3, 3, 1'b1, 1'b0)});
      checkOutput("bp rsp_id", {31'd0, rsp_id}, 32'd1);
      checkOutput("bp req_ready", {30'd0, req_ready}, 32'd0);
      checkOutput("bp busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release", {31'd0, rsp_valid}, 32'd0);

    // Reset while in PASS1 drops the operation without a response.
    @(negedge clk);
    setRequester(0, 8'h5D, 3'd2, 1'b1, 1'b0);
    req_valid = 2'b01;
    @(posedge clk); #1;
    checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midreset rsp_data", {24'd0, rsp_data}, 32'd0);
    checkOutput("midreset rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checkOutput("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("post-reset busy", {31'd0, busy}, 32'd0);
    end

    // Randomized single-requester traffic against the reference model.
    for (int k = 0; k < 30; k++) begin
      vec_t v;
      v.id    = int'($urandom_range(1, 0));
      v.data  = 8'($urandom);
      v.shamt = 3'($urandom_range(7, 0));
      v.dir   = 1'($urandom_range(1, 0));
      v.rot   = 1'($urandom_range(1, 0));
      v.expData = refModel(v.data, int'(v.shamt), v.dir, v.rot);
      v.expLat  = refLatency(int'(v.shamt), v.rot);
      applyStimulus(v);
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
